// File: rtl/square_state_writer_if.sv
// Click request and face-state result bundle for square_state_writer.
// Latency: none (wires only).
// Backpressure: clicks are only taken while busy is low; no queueing.
interface square_state_writer_if;
  logic        click;
  logic [8:0]  isX;
  logic [7:0]  isY;
  logic [2:0]  colourSet;
  logic [26:0] face_state;
  logic        busy;
  logic        done;
  logic        hit;
  logic [3:0]  hit_index;

  // Requester side: issues clicks, observes the face state and result.
  modport master (
    output click, isX, isY, colourSet,
    input  face_state, busy, done, hit, hit_index
  );

  // Writer side: owns the face state register.
  modport slave (
    input  click, isX, isY, colourSet,
    output face_state, busy, done, hit, hit_index
  );
endinterface

// File: rtl/square_state_writer.sv
// Finds which 3x3 grid square holds a clicked cursor and writes its colour.
// Latency: square k tested k+1 cycles after the click edge; done at k+2 (miss: 10).
// Backpressure: clicks while busy are dropped. Optional macro CENTRE_LOCK_EN pins square 4.
module square_state_writer #(
  parameter int         length         = 26,
  parameter int         pitch          = 30,
  parameter int         X0             = 20,
  parameter int         Y0             = 20,
  parameter logic [2:0] DEFAULT_COLOUR = 3'b111,
  parameter logic [2:0] CENTRE_COLOUR  = 3'b010
) (
  input  logic                  clock,
  input  logic                  reset,
  square_state_writer_if.slave  bus
);

  localparam logic [9:0] LEN10    = 10'(length);
  localparam logic [9:0] X0_10    = 10'(X0);
  localparam logic [9:0] Y0_10    = 10'(Y0);
  localparam logic [9:0] PITCH1   = 10'(pitch);
  localparam logic [9:0] PITCH2   = 10'(2 * pitch);

`ifdef CENTRE_LOCK_EN
  localparam logic [26:0] RESET_FACE =
    ({9{DEFAULT_COLOUR}} & ~(27'h7 << 12)) | (27'(CENTRE_COLOUR) << 12);
`else
  localparam logic [26:0] RESET_FACE = {9{DEFAULT_COLOUR}};
`endif

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t      state, stateNext;
  logic [3:0]  scanIdx, idxNext;
  logic [8:0]  cx;
  logic [7:0]  cy;
  logic [2:0]  col;
  logic        hitReg;
  logic [3:0]  hitIdx;
  logic [26:0] faceState;
  logic [9:0]  xPos, yPos, cx10, cy10;
  logic        squareHit;

  // Left edge of square k: column k mod 3.
  function automatic logic [9:0] squareX(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: return X0_10;
      4'd1, 4'd4, 4'd7: return X0_10 + PITCH1;
      default:          return X0_10 + PITCH2;
    endcase
  endfunction

  // Top edge of square k: row k div 3.
  function automatic logic [9:0] squareY(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: return Y0_10;
      4'd3, 4'd4, 4'd5: return Y0_10 + PITCH1;
      default:          return Y0_10 + PITCH2;
    endcase
  endfunction

  // Strict hit test of the captured cursor against the square being scanned.
  always_comb begin
    xPos      = squareX(scanIdx);
    yPos      = squareY(scanIdx);
    cx10      = {1'b0, cx};
    cy10      = {2'b00, cy};
    squareHit = (xPos < cx10) && (cx10 < xPos + LEN10) &&
                (yPos < cy10) && (cy10 < yPos + LEN10);
  end

  // State and scan index register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      scanIdx <= 4'd0;
    end else begin
      state   <= stateNext;
      scanIdx <= idxNext;
    end
  end

  // Next state: accept a click, scan one square per cycle, report once.
  always_comb begin
    stateNext = state;
    idxNext   = scanIdx;
    case (state)
      IDLE: begin
        if (bus.click) begin
          stateNext = SCAN;
          idxNext   = 4'd0;
        end
      end
      SCAN: begin
        if (squareHit || scanIdx == 4'd8) begin
          stateNext = REPORT;
        end else begin
          idxNext = scanIdx + 4'd1;
        end
      end
      REPORT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request capture, hit result and the face colour write on the REPORT edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      cx        <= '0;
      cy        <= '0;
      col       <= '0;
      hitReg    <= 1'b0;
      hitIdx    <= 4'd0;
      faceState <= RESET_FACE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.click) begin
            cx     <= bus.isX;
            cy     <= bus.isY;
            col    <= bus.colourSet;
            hitReg <= 1'b0;
          end
        end
        SCAN: begin
          if (squareHit) begin
            hitReg <= 1'b1;
            hitIdx <= scanIdx;
          end
        end
        REPORT: begin
          for (int k = 0; k < 9; k++) begin
`ifdef CENTRE_LOCK_EN
            if (hitReg && hitIdx == 4'(k) && k != 4) faceState[3*k +: 3] <= col;
`else
            if (hitReg && hitIdx == 4'(k)) faceState[3*k +: 3] <= col;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.face_state = faceState;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == REPORT);
  assign bus.hit        = hitReg;
  assign bus.hit_index  = hitIdx;

endmodule
